// File: rtl/mavg_window_ctrl_if.sv
// Control/status and filter-side signal bundle for mavg_window_ctrl.
// The optional stats word exists only when MAVG_WINDOW_CTRL_STATS_EN is defined.
interface mavg_window_ctrl_if #(
    parameter int LEN_W = 4
);
    logic [LEN_W-1:0] cfg_len_log;
    logic             cfg_enable;
    logic             cfg_flush;
    logic             sample_valid;
    logic             flt_clear;
    logic             flt_en;
    logic [LEN_W-1:0] flt_len_log;
    logic             out_valid;
    logic             busy;
    logic [31:0]      status;
`ifdef MAVG_WINDOW_CTRL_STATS_EN
    logic [31:0]      stats;

    modport master (
        output cfg_len_log, cfg_enable, cfg_flush, sample_valid,
        input  flt_clear, flt_en, flt_len_log,
        input  out_valid, busy, status, stats
    );

    modport slave (
        input  cfg_len_log, cfg_enable, cfg_flush, sample_valid,
        output flt_clear, flt_en, flt_len_log,
        output out_valid, busy, status, stats
    );
`else
    modport master (
        output cfg_len_log, cfg_enable, cfg_flush, sample_valid,
        input  flt_clear, flt_en, flt_len_log,
        input  out_valid, busy, status
    );

    modport slave (
        input  cfg_len_log, cfg_enable, cfg_flush, sample_valid,
        output flt_clear, flt_en, flt_len_log,
        output out_valid, busy, status
    );
`endif
endinterface

// File: rtl/mavg_window_ctrl.sv
// Moving-average window sequencer: flush on reconfig, fill count, output gating.
// Optional MAVG_WINDOW_CTRL_STATS_EN adds reconfig/drop counters on bus.stats.
module mavg_window_ctrl #(
    parameter int MAX_LEN_LOG  = 10,
    parameter int FLUSH_CYCLES = 4,
    parameter int LEN_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    mavg_window_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam int CW  = MAX_LEN_LOG + 1;
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LEN_LOG);
    localparam logic [FCW-1:0]   F_LOAD  = FCW'(FLUSH_CYCLES - 1);

    logic [LEN_W-1:0] r_cfg_len;
    logic             r_cfg_en;
    logic             r_cfg_flush;
    logic             r_cfg_flush_d;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [FCW-1:0]   r_fcnt;
    logic [CW-1:0]    r_fill;

    logic             r_clear;
    logic             r_en_gate;
    logic             r_out_valid;
    logic             r_busy;
    logic [31:0]      r_status;

    logic [1:0]       w_nxt_state;
    logic [LEN_W-1:0] w_nxt_len;
    logic [FCW-1:0]   w_nxt_fcnt;
    logic [CW-1:0]    w_nxt_fill;
    logic [LEN_W-1:0] w_req_len;
    logic [CW-1:0]    w_target;
    logic [CW-1:0]    w_fill_inc;
    logic             w_flush_edge;
    logic             w_len_chg;
    logic             w_reenter;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_len     <= '0;
            r_cfg_en      <= 1'b0;
            r_cfg_flush   <= 1'b0;
            r_cfg_flush_d <= 1'b0;
        end else begin
            r_cfg_len     <= bus.cfg_len_log;
            r_cfg_en      <= bus.cfg_enable;
            r_cfg_flush   <= bus.cfg_flush;
            r_cfg_flush_d <= r_cfg_flush;
        end
    end

    always_comb begin
        w_req_len    = (r_cfg_len > MAX_LEN) ? MAX_LEN : r_cfg_len;
        w_flush_edge = r_cfg_flush & ~r_cfg_flush_d;
        w_len_chg    = (w_req_len != r_len);
        w_target     = CW'(1) << r_len;
        w_fill_inc   = r_fill + CW'(1);
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_len   = r_len;
        w_nxt_fcnt  = r_fcnt;
        w_nxt_fill  = r_fill;
        w_reenter   = 1'b0;
        if (r_state == S_IDLE) begin
            if (r_cfg_en) begin
                w_nxt_state = S_FLUSH;
                w_nxt_len   = w_req_len;
                w_nxt_fcnt  = F_LOAD;
            end
        end else if (!r_cfg_en) begin
            w_nxt_state = S_IDLE;
        end else if (w_len_chg) begin
            w_nxt_state = S_FLUSH;
            w_nxt_len   = w_req_len;
            w_nxt_fcnt  = F_LOAD;
            w_reenter   = 1'b1;
        end else if (w_flush_edge) begin
            w_nxt_state = S_FLUSH;
            w_nxt_fcnt  = F_LOAD;
            w_reenter   = 1'b1;
        end else begin
            unique case (r_state)
                S_FLUSH: begin
                    if (r_fcnt == '0) begin
                        w_nxt_state = S_FILL;
                        w_nxt_fill  = '0;
                    end else begin
                        w_nxt_fcnt = r_fcnt - FCW'(1);
                    end
                end
                S_FILL: begin
                    if (bus.sample_valid) begin
                        w_nxt_fill = w_fill_inc;
                        if (w_fill_inc == w_target)
                            w_nxt_state = S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output flags are registered from the next state so they align with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_fcnt      <= '0;
            r_fill      <= '0;
            r_clear     <= 1'b1;
            r_en_gate   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_status    <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_len       <= w_nxt_len;
            r_fcnt      <= w_nxt_fcnt;
            r_fill      <= w_nxt_fill;
            r_clear     <= (w_nxt_state == S_IDLE) ||
                           (w_nxt_state == S_FLUSH);
            r_en_gate   <= (w_nxt_state == S_FILL) ||
                           (w_nxt_state == S_RUN);
            r_out_valid <= (w_nxt_state == S_RUN);
            r_busy      <= (w_nxt_state == S_FLUSH) ||
                           (w_nxt_state == S_FILL);
            r_status    <= {r_state, 14'b0, 8'(r_len), 8'(r_fill)};
        end
    end

    assign bus.flt_clear   = r_clear;
    assign bus.flt_en      = bus.sample_valid & r_en_gate;
    assign bus.flt_len_log = r_len;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.status      = r_status;

`ifdef MAVG_WINDOW_CTRL_STATS_EN
    logic [15:0] r_reconfig_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reconfig_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_reenter && (r_reconfig_cnt != 16'hFFFF))
                r_reconfig_cnt <= r_reconfig_cnt + 16'd1;
            if (bus.sample_valid && (r_state == S_FLUSH) &&
                (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.stats = {r_reconfig_cnt, r_drop_cnt};
`endif

endmodule
